// File: rtl/alu_pkg.sv
// Shared ALU result widths and flag bit positions.
// Used by the writeback skid buffer and its storage slots.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 3;
  localparam int TAG_W  = 5;
  localparam int CNT_W  = 16;

  localparam int FLAG_NE  = 0;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_OVF = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/result_slot.sv
// Enabled storage register for one result entry.
// A synchronous clear wins over the load enable.
module result_slot #(
  parameter int W = 40
) (
  input  logic         clock,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] slot_q;

  always_ff @(posedge clock) begin
    if (clr_i) begin
      slot_q <= '0;
    end else if (en_i) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer between the ALU and writeback.
// in_ready depends on state only, never on out_ready.
module alu_result_skid
  import alu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int FLAG_W_P = FLAG_W,
  parameter int TAG_W_P  = TAG_W,
  parameter int CNT_W_P  = CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W_P-1:0] in_data,
  input  logic [FLAG_W_P-1:0] in_flags,
  input  logic [TAG_W_P-1:0]  in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W_P-1:0] out_data,
  output logic [FLAG_W_P-1:0] out_flags,
  output logic [TAG_W_P-1:0]  out_tag,
  output logic [1:0]          occupancy,
  output logic [CNT_W_P-1:0]  xfer_count
);

  localparam int SW = DATA_W_P + FLAG_W_P + TAG_W_P;

  occ_e               state_q, state_d;
  logic [CNT_W_P-1:0] cnt_q, cnt_d;
  logic               in_fire, out_fire;
  logic               main_en, skid_en, main_from_skid;
  logic [SW-1:0]      in_word, main_d, main_q, skid_q;

  assign in_ready  = !reset && (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign in_word = {in_flags, in_tag, in_data};
  assign main_d  = main_from_skid ? skid_q : in_word;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          state_d = OCC_ONE;
          main_en = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = OCC_FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_fire) begin
          state_d        = OCC_ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush drops held entries and any input; slot contents are don't-care.
    if (flush) begin
      state_d = OCC_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  result_slot #(.W(SW)) u_main (
    .clock (clock),
    .clr_i (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  result_slot #(.W(SW)) u_skid (
    .clock (clock),
    .clr_i (reset),
    .en_i  (skid_en),
    .d_i   (in_word),
    .q_o   (skid_q)
  );

  assign out_data   = main_q[DATA_W_P-1:0];
  assign out_tag    = main_q[DATA_W_P +: TAG_W_P];
  assign out_flags  = main_q[DATA_W_P+TAG_W_P +: FLAG_W_P];
  assign occupancy  = state_q;
  assign xfer_count = cnt_q;

endmodule
